// File: rtl/fetch_queue.sv
// fetch_queue: sequential-PC fetch stage with a redirect-flushable instruction FIFO feeding decode (optional perf counters via QU_FETCH_PERF_EN)
module fetch_queue #(
  parameter int INSTR_WIDTH = 32,
  parameter int PC_WIDTH = 32,
  parameter int BUF_DEPTH = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   imem_en,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [PC_WIDTH-1:0]    pc_out
`ifdef QU_FETCH_PERF_EN
  ,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_stall
`endif
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(BUF_DEPTH);
  logic [PC_WIDTH-1:0] pc_reg, inflight_pc;
  logic inflight;
  logic [AW-1:0] head, tail;
  logic [AW:0] count;
  logic [INSTR_WIDTH+PC_WIDTH-1:0] mem [BUF_DEPTH];
  logic issue, enq, deq;
  // Request only when the in-flight response is guaranteed a free slot
  always_comb begin
    issue = !rst && !redirect_valid && ((count + {{AW{1'b0}}, inflight}) < DEPTH);
    enq = !rst && !redirect_valid && inflight;
    valid_out = !rst && (count != '0);
    deq = valid_out && ready_in;
    imem_en = issue;
    imem_addr = pc_reg;
    {instr_out, pc_out} = valid_out ? mem[head] : '0;
  end
  // PC, in-flight tracking and FIFO pointers; redirect flushes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg <= RESET_PC;
      inflight <= 1'b0;
      inflight_pc <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      pc_reg <= redirect_pc & ~PC_WIDTH'(3);
      inflight <= 1'b0;
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      pc_reg <= issue ? pc_reg + PC_WIDTH'(4) : pc_reg;
      inflight <= issue;
      inflight_pc <= issue ? pc_reg : inflight_pc;
      tail <= enq ? tail + AW'(1) : tail;
      head <= deq ? head + AW'(1) : head;
      count <= count + (AW+1)'(enq) - (AW+1)'(deq);
    end
  end
  // FIFO storage captures the memory response alongside its PC
  always_ff @(posedge clk) begin
    if (enq) mem[tail] <= {imem_rdata, inflight_pc};
  end
`ifdef QU_FETCH_PERF_EN
  // Handshake and back-pressure counters survive redirects, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall <= '0;
    end else begin
      perf_fetched <= deq ? perf_fetched + 32'd1 : perf_fetched;
      perf_stall <= (valid_out && !ready_in) ? perf_stall + 32'd1 : perf_stall;
    end
  end
`endif
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Front-end fetch stage sitting directly upstream of decode.
- Generates sequential PCs and issues reads to a fixed 1-cycle-latency synchronous instruction memory.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- Handles redirects (branch/flush) by discarding all buffered and in-flight instructions and restarting at the redirect PC.

Parameters:
- INSTR_WIDTH, 32: instruction word width.
- BUF_DEPTH, 4: FIFO entries; power of two, >= 2; sustains 1 instr/cycle when >= 3.
- RESET_PC, 0: PC fetched first after reset (pc_t value).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- redirect_valid  in  1  flush and restart fetch this cycle.
- redirect_pc  in  pc_t  restart PC; bits [1:0] ignored (treated as 0).
- imem_en  out  1  instruction memory read strobe.
- imem_addr  out  pc_t  read address (byte address).
- imem_rdata  in  INSTR_WIDTH  read data; valid the cycle after imem_en.
- valid_out  out  1  head entry valid towards decode.
- ready_in  in  1  decode accepts head entry.
- instr_out  out  INSTR_WIDTH  head instruction (instr_in of decode).
- pc_out  out  pc_t  head PC (pc_in of decode).

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: pc_reg=RESET_PC; FIFO empty; inflight=0. valid_out=0, instr_out=0, pc_out=0, imem_en=0 during the rst cycle.
- State:
  - pc_reg: next PC to request.
  - inflight flag plus inflight_pc: request issued last cycle.
  - FIFO of {instr, pc} with head/tail pointers wrapping modulo BUF_DEPTH, and count 0..BUF_DEPTH.
- Issue (combinational from registered state):
  - issue = !rst && !redirect_valid && (count + inflight) < BUF_DEPTH.
  - imem_en=issue; imem_addr=pc_reg.
  - On issue: pc_reg <= pc_reg+4 (wraps modulo 2^width); inflight <= 1; inflight_pc <= pc_reg. Otherwise inflight <= 0.
  - The slot reservation guarantees a response always has a free entry. It does not credit a same-cycle dequeue.
- Response: when inflight=1 and no redirect this cycle, {imem_rdata, inflight_pc} is written at tail at the clock edge.
- Dequeue: a transfer occurs when valid_out && ready_in; head advances.
  - Simultaneous enqueue and dequeue leaves count unchanged.
- Outputs:
  - valid_out = (count != 0).
  - instr_out/pc_out = head entry when valid_out=1, else 0.
  - Outputs hold stable while valid_out=1 and ready_in=0.
- Latency:
  - Request at cycle N gives the entry visible at N+2.
  - First valid_out after reset release is 2 cycles after the first non-reset cycle.
- Redirect at cycle N (highest priority after rst):
  - imem_en=0 in N.
  - Response arriving in N is dropped.
  - FIFO cleared (count=0, pointers to 0); inflight <= 0.
  - pc_reg <= {redirect_pc[w-1:2],2'b00}.
  - First new request in N+1; valid_out earliest at N+3.
  - A dequeue handshake in cycle N still counts as consumed by decode.
- Reset mid-operation: identical to reset; all buffered and in-flight data lost; pc_reg=RESET_PC.
- Full: count=BUF_DEPTH with ready_in=0. No issue; pc_reg holds; no entry lost or duplicated.
- No instruction inspection: invalid encodings pass through unmodified (decode flags them).

Optional Feature:
- Macro QU_FETCH_PERF_EN.
- When defined, adds two outputs, both 32-bit counters, cleared by rst and not cleared by redirect:
  - perf_fetched: increments on each dequeue handshake.
  - perf_stall: increments each cycle with valid_out=1 && ready_in=0.
  - Both wrap on overflow.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, ready_in=1, memory returns word = addr|0x13.
  - valid_out rises 2 cycles after release.
  - pc_out sequence 0,4,8,12 on consecutive cycles.
  - instr_out 0x13, 0x17, 0x1B, 0x1F.
- ready_in=0 for 10 cycles, BUF_DEPTH=4.
  - imem_en stops after 4 requests; count=4.
  - Head holds pc 0 with stable instr_out.
  - Releasing ready_in yields pcs 0,4,8,12,16 with no gaps or duplicates.
- Redirect at cycle N with redirect_pc=0x103, queue holding 3 entries and one in flight.
  - valid_out=0 from N+1 to N+2.
  - At N+3, pc_out=0x100; no old PC ever appears after N.
- Memory returns 0xFFFF_FFFF at address 8.
  - Entry is delivered unchanged: instr_out=0xFFFF_FFFF, pc_out=8.
- rst asserted for 1 cycle while the queue is full and a request is in flight.
  - Next cycle valid_out=0 and imem_en=1 with imem_addr=RESET_PC.
- With QU_FETCH_PERF_EN: 5 accepted instructions and 3 stalled cycles.
  - perf_fetched=5, perf_stall=3.
  - A redirect leaves both values unchanged.
